// File: rtl/hub75_frame_loader_if.sv
// Pixel stream handshake into the HUB75 frame loader.
//   in_data  : pixel byte, [5:4]=R, [3:2]=G, [1:0]=B, [7:6] unused
//   in_sof   : marks in_data as pixel 0 of a frame
//   in_valid : in_data/in_sof are valid
//   in_ready : loader accepts the byte this cycle
// master = pixel source, slave = loader.
`timescale 1ns/1ps
interface hub75_frame_loader_if;
  logic [7:0] in_data;
  logic       in_sof;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_sof, output in_valid, input in_ready);
  modport slave  (input in_data, input in_sof, input in_valid, output in_ready);
endinterface

// File: rtl/hub75_frame_loader.sv
// Double-buffered 64x32, 2-bit-per-channel framebuffer for the HUB75 driver.
// Loads a byte-per-pixel stream into the hidden bank and swaps banks only on
// the scanner's frame_tick, so a partially loaded frame is never displayed.
// Ports:
//   clk, rst    : single clock, synchronous active-high reset
//   pix         : pixel stream handshake (slave side)
//   frame_tick  : scanner end-of-frame pulse
//   column/ADDR : scanner read position, colorCycle = PWM phase 0..2
//   RGB0/RGB1   : {R,G,B} for rows ADDR and ADDR+PIXEL_LINES, 2-cycle latency
//   frame_done  : one-cycle pulse on a buffer swap
`timescale 1ns/1ps
module hub75_frame_loader #(
  parameter int PIXEL_COLUMNS = 64,
  parameter int PIXEL_LINES   = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  hub75_frame_loader_if.slave              pix,
  input  logic                             frame_tick,
  input  logic [$clog2(PIXEL_COLUMNS)-1:0] column,
  input  logic [$clog2(PIXEL_LINES)-1:0]   ADDR,
  input  logic [1:0]                       colorCycle,
  output logic [2:0]                       RGB0,
  output logic [2:0]                       RGB1,
  output logic                             frame_done
);
  localparam int COL_W      = $clog2(PIXEL_COLUMNS);
  localparam int ROW_W      = $clog2(PIXEL_LINES);
  localparam int HALF_W     = COL_W + ROW_W;
  localparam int CNT_W      = HALF_W + 1;
  localparam int HALF_DEPTH = PIXEL_COLUMNS * PIXEL_LINES;
  localparam logic [CNT_W-1:0] LAST_PIXEL = CNT_W'(2 * HALF_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_SWAP} state_t;

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic             display_bank;

  // Index = {bank, row[3:0], column}
  logic [5:0] mem_top [0:2*HALF_DEPTH-1];
  logic [5:0] mem_bot [0:2*HALF_DEPTH-1];

  logic             accept;
  logic             wr_en;
  logic [CNT_W-1:0] wr_pix;
  logic [HALF_W:0]  wr_addr;
  logic             wr_bottom;
  logic             unused_hi;

  logic [5:0] rd_top;
  logic [5:0] rd_bot;
  logic [1:0] cc_q;

  assign unused_hi = ^pix.in_data[7:6];

  always_comb begin
    accept    = pix.in_valid && pix.in_ready;
    // In IDLE only a start-of-frame byte is stored; other bytes are dropped.
    wr_en     = accept && (pix.in_sof || (state == LOAD));
    wr_pix    = pix.in_sof ? '0 : counter;
    // Pixel index MSB is row[4]: selects the top or bottom half memory.
    wr_bottom = wr_pix[CNT_W-1];
    wr_addr   = {~display_bank, wr_pix[HALF_W-1:0]};
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_bottom) mem_bot[wr_addr] <= pix.in_data[5:0];
      else           mem_top[wr_addr] <= pix.in_data[5:0];
    end
  end

  always_ff @(posedge clk) begin
    rd_top <= mem_top[{display_bank, ADDR, column}];
    rd_bot <= mem_bot[{display_bank, ADDR, column}];
    cc_q   <= colorCycle;
  end

  function automatic logic [2:0] shade(input logic [5:0] px, input logic [1:0] cc);
    return {px[5:4] > cc, px[3:2] > cc, px[1:0] > cc};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      RGB0 <= '0;
      RGB1 <= '0;
    end else begin
      RGB0 <= shade(rd_top, cc_q);
      RGB1 <= shade(rd_bot, cc_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      counter      <= '0;
      display_bank <= 1'b0;
      pix.in_ready <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          pix.in_ready <= 1'b1;
          if (accept && pix.in_sof) begin
            counter <= CNT_W'(1);
            state   <= LOAD;
          end
        end
        LOAD: begin
          pix.in_ready <= 1'b1;
          if (accept) begin
            if (pix.in_sof) begin
              counter <= CNT_W'(1);
            end else if (counter == LAST_PIXEL) begin
              state        <= WAIT_SWAP;
              pix.in_ready <= 1'b0;
            end else begin
              counter <= counter + CNT_W'(1);
            end
          end
        end
        WAIT_SWAP: begin
          if (frame_tick) begin
            display_bank <= ~display_bank;
            frame_done   <= 1'b1;
            pix.in_ready <= 1'b1;
            counter      <= '0;
            state        <= IDLE;
          end
        end
        default: begin
          state        <= IDLE;
          pix.in_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hub75_frame_loader.sv
`timescale 1ns/1ps
module tb_hub75_frame_loader;
  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic [5:0] column;
  logic [3:0] ADDR;
  logic [1:0] colorCycle;
  logic [2:0] RGB0, RGB1;
  logic       frame_done;

  always #5 clk = ~clk;

  hub75_frame_loader_if pix();

  hub75_frame_loader #(.PIXEL_COLUMNS(64), .PIXEL_LINES(16)) dut (
    .clk(clk), .rst(rst), .pix(pix), .frame_tick(frame_tick),
    .column(column), .ADDR(ADDR), .colorCycle(colorCycle),
    .RGB0(RGB0), .RGB1(RGB1), .frame_done(frame_done)
  );

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Framebuffer as two banks of 2048 pixels indexed row*64+column.
  int  mem   [2][2048];
  bit  known [2][2048];
  int  m_mode = 0;            // 0 idle, 1 loading, 2 waiting for swap
  int  m_pos  = 0;
  int  m_disp = 0;
  bit  m_ready = 1'b0;
  bit  m_done  = 1'b0;
  int  s1_top, s1_bot, s1_cc;
  bit  s1_known = 1'b0;
  logic [2:0] e0 = '0, e1 = '0;
  bit  e_known = 1'b0;
  int  ti, bi, ld;

  function automatic logic [2:0] model_rgb(input int v, input int cc);
    logic [2:0] r;
    for (int ch = 0; ch < 3; ch++) r[ch] = (((v >> (2 * ch)) & 3) > cc);
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_pos = 0; m_disp = 0; m_ready = 1'b0; m_done = 1'b0;
      e0 = '0; e1 = '0; e_known = 1'b1; s1_known = 1'b0;
    end else begin
      e_known = s1_known;
      if (s1_known) begin
        e0 = model_rgb(s1_top, s1_cc);
        e1 = model_rgb(s1_bot, s1_cc);
      end
      ti = int'(ADDR) * 64 + int'(column);
      bi = (int'(ADDR) + 16) * 64 + int'(column);
      s1_known = known[m_disp][ti] && known[m_disp][bi];
      s1_top = mem[m_disp][ti];
      s1_bot = mem[m_disp][bi];
      s1_cc  = int'(colorCycle);
      m_done = 1'b0;
      ld = 1 - m_disp;
      if (m_mode == 2) begin
        if (frame_tick) begin
          m_disp = 1 - m_disp; m_done = 1'b1; m_mode = 0;
        end
      end else if (pix.in_valid && m_ready) begin
        if (pix.in_sof) begin
          mem[ld][0] = int'(pix.in_data[5:0]); known[ld][0] = 1'b1;
          m_pos = 1; m_mode = 1;
        end else if (m_mode == 1) begin
          mem[ld][m_pos] = int'(pix.in_data[5:0]); known[ld][m_pos] = 1'b1;
          m_pos++;
          if (m_pos == 2048) m_mode = 2;
        end
      end
      m_ready = (m_mode != 2);
    end
  end

  always @(negedge clk) begin
    check("in_ready", {31'b0, pix.in_ready}, {31'b0, m_ready});
    check("frame_done", {31'b0, frame_done}, {31'b0, m_done});
    if (e_known) begin
      check("RGB0", {29'b0, RGB0}, {29'b0, e0});
      check("RGB1", {29'b0, RGB1}, {29'b0, e1});
    end
    if (frame_done === 1'b1) done_cnt++;
  end

  // ---------------- stimulus ----------------
  // Frame 0: rows 0-15 carry R=row[1:0], G=col[1:0]; row 21 full white; rest black.
  function automatic int pix_val(input int kind, input int idx);
    int r, c;
    r = idx / 64; c = idx % 64;
    case (kind)
      0: pix_val = (r < 16) ? (((r % 4) << 4) | ((c % 4) << 2)) : ((r == 21) ? 'h3F : 0);
      1: pix_val = (idx == 0) ? 'h21 : 0;
      2: pix_val = 'h2A;
      default: pix_val = 'h3F;
    endcase
  endfunction

  task automatic send_byte(input int d, input bit s);
    int k;
    pix.in_valid = 1'b1; pix.in_data = 8'(d); pix.in_sof = s;
    k = 0;
    while (pix.in_ready !== 1'b1 && k < 100) begin
      @(negedge clk); k++;
    end
    if (k >= 100) begin
      tests++; fails++;
      $display("FAIL handshake_timeout: in_ready=%b required 1", pix.in_ready);
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input int kind, input int first, input int count);
    for (int i = first; i < first + count; i++) send_byte(pix_val(kind, i), i == first);
    pix.in_valid = 1'b0; pix.in_sof = 1'b0;
  endtask

  task automatic read_check(input string name, input int a, input int c, input int cc,
                            input logic [2:0] x0, input logic [2:0] x1);
    ADDR = 4'(a); column = 6'(c); colorCycle = 2'(cc);
    repeat (2) @(negedge clk);
    check({name, "_rgb0"}, {29'b0, RGB0}, {29'b0, x0});
    check({name, "_rgb1"}, {29'b0, RGB1}, {29'b0, x1});
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    check("swap_done", {31'b0, frame_done}, 32'd1);
    check("swap_ready", {31'b0, pix.in_ready}, 32'd1);
    @(negedge clk);
    check("swap_done_drop", {31'b0, frame_done}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; column = '0; ADDR = '0; colorCycle = '0;
    pix.in_valid = 1'b0; pix.in_sof = 1'b0; pix.in_data = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, pix.in_ready}, 32'd0);
    check("rst_done", {31'b0, frame_done}, 32'd0);
    check("rst_rgb0", {29'b0, RGB0}, 32'd0);
    check("rst_rgb1", {29'b0, RGB1}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'b0, pix.in_ready}, 32'd1);

    // Bytes without start-of-frame are consumed and dropped.
    for (int i = 0; i < 10; i++) send_byte('h3F, 1'b0);
    pix.in_valid = 1'b0;
    @(negedge clk);

    send_frame(0, 0, 2048);
    check("full_ready_low", {31'b0, pix.in_ready}, 32'd0);
    repeat (4) @(negedge clk);
    check("no_done_before_tick", done_cnt, 32'd0);
    pulse_tick();
    check("one_done", done_cnt, 32'd1);

    read_check("a_r5c6_cc0", 5, 6, 0, 3'b110, 3'b111);
    read_check("a_r5c6_cc1", 5, 6, 1, 3'b010, 3'b111);
    read_check("a_r5c6_cc2", 5, 6, 2, 3'b000, 3'b111);
    read_check("a_r4c0_cc0", 4, 0, 0, 3'b000, 3'b000);
    read_check("a_r4c0_cc1", 4, 0, 1, 3'b000, 3'b000);
    read_check("a_r0c1_cc0", 0, 1, 0, 3'b010, 3'b000);
    read_check("a_r0c0_cc0", 0, 0, 0, 3'b000, 3'b000);

    // 700 pixels of white, then a resync frame that is black except pixel 0.
    send_frame(3, 0, 700);
    send_frame(1, 0, 2048);
    check("resync_ready_low", {31'b0, pix.in_ready}, 32'd0);
    pulse_tick();
    read_check("b_r0c0_cc0", 0, 0, 0, 3'b101, 3'b000);
    read_check("b_r0c0_cc1", 0, 0, 1, 3'b100, 3'b000);
    read_check("b_r5c6_cc0", 5, 6, 0, 3'b000, 3'b000);

    // Reset while waiting to swap, with frame_tick in the same cycle.
    send_frame(2, 0, 2048);
    rst = 1'b1; frame_tick = 1'b1;
    @(negedge clk);
    rst = 1'b0; frame_tick = 1'b0;
    check("rst_wait_done", {31'b0, frame_done}, 32'd0);
    check("rst_wait_ready", {31'b0, pix.in_ready}, 32'd0);
    @(negedge clk);
    check("rst_wait_ready_after", {31'b0, pix.in_ready}, 32'd1);
    read_check("c_r0c0_cc0", 0, 0, 0, 3'b101, 3'b000);
    check("done_count_after_rst", done_cnt, 32'd2);

    for (int i = 0; i < 64; i++) begin
      ADDR = 4'(i % 16); column = 6'((i * 5) % 64); colorCycle = 2'(i % 3);
      repeat (2) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
